// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared types and defaults for the MIPS-lite execute-stage units.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        MS_IDLE   = 2'd0,
        MS_CALC   = 2'd1,
        MS_NEG_LO = 2'd2,
        MS_NEG_HI = 2'd3
    } mult_state_e;

endpackage

`default_nettype wire

// File: rtl/add_rca_cla.sv
// ============================================================================
// Module : cla_4bits / add_rca_cla
// Brief  : 4-bit carry-lookahead slice and a WIDTH-bit adder that ripples the
//          carry through a chain of those slices.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:1] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ {c[3], c[2], c[1], cin};
endmodule

module add_rca_cla
    import mips_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int SLICES = WIDTH / 4;

    logic [SLICES:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar i = 0; i < SLICES; i++) begin : g_slice
            cla_4bits u_cla (
                .a    (a[4*i +: 4]),
                .b    (b[4*i +: 4]),
                .cin  (carry[i]),
                .sum  (sum[4*i +: 4]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    assign cout = carry[SLICES];
endmodule

`default_nettype wire

// File: rtl/mult_seq.sv
// ============================================================================
// Module : mult_seq
// Brief  : Multi-cycle radix-2 shift-and-add 32x32->64 multiplier (MULT/MULTU)
//          producing the HI/LO pair with a fixed 34-cycle latency.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_seq
    import mips_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int               MSB    = WIDTH - 1;
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    mult_state_e      state_q;
    logic [CNT_W-1:0] count_q;
    logic             neg_q;
    logic             flag_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mq_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] neg_a;
    logic [WIDTH-1:0] neg_b;
    logic             neg_a_co;
    logic             neg_b_co;
    logic             unused_co;
    logic             neg_d;
    logic [WIDTH-1:0] mcand_d;
    logic [WIDTH-1:0] mq_d;

    add_rca_cla #(.WIDTH(WIDTH)) u_neg_a (
        .a    (~op_a),
        .b    (c_ZERO),
        .cin  (1'b1),
        .sum  (neg_a),
        .cout (neg_a_co)
    );

    add_rca_cla #(.WIDTH(WIDTH)) u_neg_b (
        .a    (~op_b),
        .b    (c_ZERO),
        .cin  (1'b1),
        .sum  (neg_b),
        .cout (neg_b_co)
    );

    assign unused_co = neg_a_co ^ neg_b_co;
    assign neg_d     = is_signed & (op_a[MSB] ^ op_b[MSB]);
    assign mcand_d   = (is_signed && op_a[MSB]) ? neg_a : op_a;
    assign mq_d      = (is_signed && op_b[MSB]) ? neg_b : op_b;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] iter_sum;
    logic             iter_co;

    assign addend = mq_q[0] ? mcand_q : c_ZERO;

    add_rca_cla #(.WIDTH(WIDTH)) u_iter (
        .a    (acc_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (iter_sum),
        .cout (iter_co)
    );

    // One negator serves both result halves: low word first, then the high
    // word with the low-half carry folded in as carry-in.
    logic             sel_hi;
    logic [WIDTH-1:0] res_a;
    logic             res_cin;
    logic [WIDTH-1:0] res_sum;
    logic             res_co;

    assign sel_hi  = (state_q == MS_NEG_HI);
    assign res_a   = sel_hi ? ~acc_q : ~mq_q;
    assign res_cin = sel_hi ? flag_q : 1'b1;

    add_rca_cla #(.WIDTH(WIDTH)) u_res (
        .a    (res_a),
        .b    (c_ZERO),
        .cin  (res_cin),
        .sum  (res_sum),
        .cout (res_co)
    );

    // The carry lands in acc's MSB on each shift, so the would-be guard bit
    // above it is always zero and is not stored.  The negated low word is
    // parked in mq so hi/lo commit together and a late cancel leaves both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MS_IDLE;
            count_q <= '0;
            neg_q   <= 1'b0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mcand_q <= '0;
            mq_q    <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (cancel && (state_q != MS_IDLE)) begin
                state_q <= MS_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    MS_IDLE: begin
                        if (start && !cancel) begin
                            neg_q   <= neg_d;
                            mcand_q <= mcand_d;
                            mq_q    <= mq_d;
                            acc_q   <= '0;
                            count_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= MS_CALC;
                        end
                    end
                    MS_CALC: begin
                        acc_q   <= {iter_co, iter_sum[WIDTH-1:1]};
                        mq_q    <= {iter_sum[0], mq_q[WIDTH-1:1]};
                        count_q <= count_q + 1'b1;
                        if (count_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= MS_NEG_LO;
                        end
                    end
                    MS_NEG_LO: begin
                        if (neg_q) begin
                            mq_q   <= res_sum;
                            flag_q <= res_co;
                        end else begin
                            flag_q <= 1'b0;
                        end
                        state_q <= MS_NEG_HI;
                    end
                    MS_NEG_HI: begin
                        hi_q    <= neg_q ? res_sum : acc_q;
                        lo_q    <= mq_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= MS_IDLE;
                    end
                    default: begin
                        state_q <= MS_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq.sv
// ============================================================================
// Module : tb_mult_seq
// Brief  : Scoreboard testbench for mult_seq with directed and random products.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_seq;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic        is_signed = 1'b0;
    logic        cancel    = 1'b0;
    logic [31:0] op_a      = '0;
    logic [31:0] op_b      = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          e0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_done = 1'b0;

    mult_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] xa;
        logic signed [63:0] xb;
        if (s) begin
            xa = {{32{a[31]}}, a};
            xb = {{32{b[31]}}, b};
            return xa * xb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse is matched against the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("done_width", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_hi", 64'(hi), 64'(mon_e.hi));
                chk("sb_lo", 64'(lo), 64'(mon_e.lo));
                chk("sb_latency", 64'(cyc - mon_e.e0), 64'd34);
            end
        end
        prev_done <= done;
    end

    // Called just after a negedge; start is sampled at the following posedge.
    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        exp_t        e;
        p    = ref_mul(s, a, b);
        e.hi = p[63:32];
        e.lo = p[31:0];
        e.e0 = cyc + 1;
        sb.push_back(e);
        start     = 1'b1;
        is_signed = s;
        op_a      = a;
        op_b      = b;
        @(negedge clk);
        start     = 1'b0;
        is_signed = 1'($urandom_range(0, 1));
        op_a      = $urandom;
        op_b      = $urandom;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    bit          d_s  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] d_a  [6] = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic [31:0] d_b  [6] = '{32'd5, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 32'h80000000, 32'd1};
    logic [31:0] d_hi [6] = '{32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h40000000, 32'hFFFFFFFF};
    logic [31:0] d_lo [6] = '{32'hF, 32'h1, 32'hFFFFFFEB, 32'h1, 32'h0, 32'h80000000};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            issue(d_s[i], d_a[i], d_b[i]);
            wait_done();
            chk("dir_hi", 64'(hi), 64'(d_hi[i]));
            chk("dir_lo", 64'(lo), 64'(d_lo[i]));
            @(negedge clk);
            chk("dir_busy_idle", 64'(busy), 64'd0);
        end

        // start raised in the done cycle is accepted
        issue(1'b0, 32'd3, 32'd5);
        wait_done();
        issue(1'b0, 32'd6, 32'd7);
        wait_done();
        chk("b2b_lo", 64'(lo), 64'h2A);

        // start pulse mid-CALC is ignored
        @(negedge clk);
        issue(1'b0, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        start = 1'b1;
        op_a  = 32'd9;
        op_b  = 32'd9;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_busy", 64'(busy), 64'd1);
        wait_done();
        chk("ignored_start_lo", 64'(lo), 64'd15);

        // cancel on the 10th CALC cycle
        @(negedge clk);
        issue(1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_done", 64'(done), 64'd0);
        void'(sb.pop_back());
        repeat (40) @(negedge clk);
        chk("cancel_hi_kept", 64'(hi), 64'd0);
        chk("cancel_lo_kept", 64'(lo), 64'd15);

        // cancel together with start in IDLE suppresses the start
        start  = 1'b1;
        cancel = 1'b1;
        op_a   = 32'd100;
        op_b   = 32'd100;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        chk("cancel_start_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        chk("cancel_start_lo", 64'(lo), 64'd15);

        for (int n = 0; n < 30; n++) begin
            issue(1'($urandom_range(0, 1)), pick(), pick());
            wait_done();
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // asynchronous reset mid-CALC
        @(negedge clk);
        issue(1'b0, 32'd3, 32'd5);
        wait_done();
        @(negedge clk);
        issue(1'b1, 32'h1234_5678, 32'hFFFF_0000);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 32'd2, 32'd2);
        wait_done();
        chk("post_rst_lo", 64'(lo), 64'd4);
        chk("post_rst_hi", 64'(hi), 64'd0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
